// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`timescale 1ns/1ps
package mem_arb_pkg;

  localparam int DATA_LENGTH = 8;
  localparam int ADDR_LENGTH = 4;

  // Owner encoding carried through the tag pipeline and the round-robin state.
  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  // Tag travelling alongside each issued memory command.
  typedef struct packed {
    logic valid;
    logic owner;
    logic is_read;
  } tag_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester A/B handshakes, shared read return and memory command port.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req until gnt; no backpressure on read return.
// Modports: master = requesters plus the memory model, slave = the arbiter.
`timescale 1ns/1ps
interface mem_port_arbiter_if import mem_arb_pkg::*; #(
  parameter int data_length = DATA_LENGTH,
  parameter int addr_length = ADDR_LENGTH
);

  logic                   req_a;
  logic                   we_a;
  logic [addr_length-1:0] addr_a;
  logic [data_length-1:0] wdata_a;
  logic                   gnt_a;
  logic                   rvalid_a;

  logic                   req_b;
  logic                   we_b;
  logic [addr_length-1:0] addr_b;
  logic [data_length-1:0] wdata_b;
  logic                   gnt_b;
  logic                   rvalid_b;

  logic [data_length-1:0] rdata;

  logic                   mem_read_write;
  logic [addr_length-1:0] mem_address;
  logic [data_length-1:0] mem_data_in;
  logic [data_length-1:0] mem_data_out;

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    output mem_data_out,
    input  gnt_a, rvalid_a, gnt_b, rvalid_b, rdata,
    input  mem_read_write, mem_address, mem_data_in
  );

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    input  mem_data_out,
    output gnt_a, rvalid_a, gnt_b, rvalid_b, rdata,
    output mem_read_write, mem_address, mem_data_in
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; remembers the last granted owner.
// Latency: grant is combinational in the request cycle.
// Backpressure: the loser simply keeps requesting; grants are forced low in reset.
// Ports: clk, rst_n, req_a/req_b in, gnt_a/gnt_b out.
`timescale 1ns/1ps
module rr_arb2 import mem_arb_pkg::*; (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  logic last_owner_q;
  logic last_owner_d;

  // Under contention the requester that did not win last time goes first.
  // rst_n gating keeps both grants low while reset is held.
  always_comb begin
    gnt_a = rst_n & req_a & (~req_b | (last_owner_q == OWNER_B));
    gnt_b = rst_n & req_b & (~req_a | (last_owner_q == OWNER_A));
  end

  always_comb begin
    last_owner_d = last_owner_q;
    if (gnt_a) begin
      last_owner_d = OWNER_A;
    end else if (gnt_b) begin
      last_owner_d = OWNER_B;
    end
  end

  // Reset to B so that A wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q <= OWNER_B;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between requesters A and B.
// Latency: gnt is combinational; read data returns with rvalid 2 cycles after gnt.
// Backpressure: loser holds req until granted; one access per cycle, no return stall.
// Ports: clk, rst_n, bus (slave modport: A/B handshakes, rdata, memory command/data).
`timescale 1ns/1ps
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int data_length = DATA_LENGTH,
  parameter int addr_length = ADDR_LENGTH
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  logic gnt_a;
  logic gnt_b;

  logic                   mem_read_write_q, mem_read_write_d;
  logic [addr_length-1:0] mem_address_q,    mem_address_d;
  logic [data_length-1:0] mem_data_in_q,    mem_data_in_d;

  // s1: command sitting on the memory port; s2: read data now on mem_data_out.
  tag_t s1_q, s1_d;
  tag_t s2_q;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .req_a (bus.req_a),
    .req_b (bus.req_b),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  // Issue stage. With no grant the port falls back to a read of the held
  // address; it is harmless because its tag is invalid.
  always_comb begin
    mem_read_write_d = 1'b0;
    mem_address_d    = mem_address_q;
    mem_data_in_d    = mem_data_in_q;
    s1_d             = '0;
    if (gnt_a) begin
      mem_read_write_d = bus.we_a;
      mem_address_d    = bus.addr_a;
      mem_data_in_d    = bus.wdata_a;
      s1_d.valid       = 1'b1;
      s1_d.owner       = OWNER_A;
      s1_d.is_read     = ~bus.we_a;
    end else if (gnt_b) begin
      mem_read_write_d = bus.we_b;
      mem_address_d    = bus.addr_b;
      mem_data_in_d    = bus.wdata_b;
      s1_d.valid       = 1'b1;
      s1_d.owner       = OWNER_B;
      s1_d.is_read     = ~bus.we_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read_write_q <= 1'b0;
      mem_address_q    <= '0;
      mem_data_in_q    <= '0;
      s1_q             <= '0;
      s2_q             <= '0;
    end else begin
      mem_read_write_q <= mem_read_write_d;
      mem_address_q    <= mem_address_d;
      mem_data_in_q    <= mem_data_in_d;
      s1_q             <= s1_d;
      s2_q             <= s1_q;
    end
  end

  assign bus.gnt_a          = gnt_a;
  assign bus.gnt_b          = gnt_b;
  assign bus.mem_read_write = mem_read_write_q;
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_data_in    = mem_data_in_q;

  // Memory output is already registered inside the memory, so it is
  // returned straight through, qualified by the stage-2 tag.
  assign bus.rdata    = bus.mem_data_out;
  assign bus.rvalid_a = s2_q.valid & s2_q.is_read & (s2_q.owner == OWNER_A);
  assign bus.rvalid_b = s2_q.valid & s2_q.is_read & (s2_q.owner == OWNER_B);

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.data_length(DW), .addr_length(AW)) bus ();

  mem_port_arbiter #(.data_length(DW), .addr_length(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Single-port synchronous memory model: write when read_write=1, else registered read.
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] mem_dout;
  always @(posedge clk) begin
    if (bus.mem_read_write) mem[bus.mem_address] <= bus.mem_data_in;
    else                    mem_dout <= mem[bus.mem_address];
  end
  assign bus.mem_data_out = mem_dout;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          owner;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } op_t;

  exp_t exp_q[$];
  op_t  pa[$];
  op_t  pb[$];
  logic gnt_log[$];
  exp_t mon_e;

  int nchecks = 0;
  int nerrs   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nchecks++;
    if (act !== req) begin
      nerrs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic op_t wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    op_t o;
    o.we = 1'b1; o.addr = a; o.wdata = d; o.exp = '0;
    return o;
  endfunction

  function automatic op_t rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
    op_t o;
    o.we = 1'b0; o.addr = a; o.wdata = '0; o.exp = e;
    return o;
  endfunction

  // Monitor: every rvalid pops the oldest expected read and compares.
  always @(negedge clk) begin
    if (rst_n && (bus.rvalid_a || bus.rvalid_b)) begin
      chk("rvalid_onehot", 32'(bus.rvalid_a & bus.rvalid_b), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rvalid_owner", 32'(bus.rvalid_b), 32'(mon_e.owner));
        chk("rdata", 32'(bus.rdata), 32'(mon_e.data));
        chk("rvalid_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  // Presents the heads of pa/pb as requests until both queues are consumed.
  task automatic run_ops(input bit push_exp);
    int   guard;
    logic ra, rb;
    exp_t e;
    guard = 0;
    while ((pa.size() > 0 || pb.size() > 0) && guard < 100) begin
      @(posedge clk); #1;
      ra = (pa.size() > 0);
      rb = (pb.size() > 0);
      bus.req_a = ra;
      bus.req_b = rb;
      if (ra) begin bus.we_a = pa[0].we; bus.addr_a = pa[0].addr; bus.wdata_a = pa[0].wdata; end
      if (rb) begin bus.we_b = pb[0].we; bus.addr_b = pb[0].addr; bus.wdata_b = pb[0].wdata; end
      @(negedge clk);
      chk("gnt_a_without_req", 32'(bus.gnt_a & ~ra), 32'd0);
      chk("gnt_b_without_req", 32'(bus.gnt_b & ~rb), 32'd0);
      if (ra && rb) chk("contention_one_gnt", 32'(bus.gnt_a) + 32'(bus.gnt_b), 32'd1);
      else          chk("solo_gnt_same_cycle", 32'(ra ? bus.gnt_a : bus.gnt_b), 32'd1);
      if (bus.gnt_a && ra) begin
        gnt_log.push_back(OWNER_A);
        if (push_exp && !pa[0].we) begin
          e.owner = OWNER_A; e.data = pa[0].exp; e.cyc = cyc + 2;
          exp_q.push_back(e);
        end
        void'(pa.pop_front());
      end else if (bus.gnt_b && rb) begin
        gnt_log.push_back(OWNER_B);
        if (push_exp && !pb[0].we) begin
          e.owner = OWNER_B; e.data = pb[0].exp; e.cyc = cyc + 2;
          exp_q.push_back(e);
        end
        void'(pb.pop_front());
      end
      guard++;
    end
    if (pa.size() > 0 || pb.size() > 0) begin
      chk("run_ops_timeout", 32'd1, 32'd0);
      pa.delete();
      pb.delete();
    end
    @(posedge clk); #1;
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // seq bit i is the owner expected for the i-th grant.
  task automatic check_log(input string nm, input logic [7:0] seq, input int n);
    chk({nm, "_count"}, 32'(gnt_log.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < gnt_log.size()) chk(nm, 32'(gnt_log[i]), 32'(seq[i]));
    end
    gnt_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = '0; bus.wdata_a = '0;
    bus.req_b = 1'b1; bus.we_b = 1'b0; bus.addr_b = '0; bus.wdata_b = '0;

    // Reset state, with both requests held to show grants are suppressed.
    repeat (2) @(negedge clk);
    chk("rst_mem_read_write", 32'(bus.mem_read_write), 32'd0);
    chk("rst_mem_address",    32'(bus.mem_address),    32'd0);
    chk("rst_mem_data_in",    32'(bus.mem_data_in),    32'd0);
    chk("rst_rvalid_a",       32'(bus.rvalid_a),       32'd0);
    chk("rst_rvalid_b",       32'(bus.rvalid_b),       32'd0);
    chk("rst_gnt_a",          32'(bus.gnt_a),          32'd0);
    chk("rst_gnt_b",          32'(bus.gnt_b),          32'd0);
    @(posedge clk); #1;
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    rst_n = 1'b1;

    // A writes 0x5A at 3 then reads it back.
    pa.push_back(wr(4'd3, 8'h5A));
    pa.push_back(rd(4'd3, 8'h5A));
    run_ops(1'b1); drain();
    check_log("t1_order", 8'b00, 2);

    // A preloads 0..3 with 0x10..0x13, then 4 back-to-back reads.
    for (int i = 0; i < 4; i++) pa.push_back(wr(4'(i), 8'(8'h10 + i)));
    for (int i = 0; i < 4; i++) pa.push_back(rd(4'(i), 8'(8'h10 + i)));
    run_ops(1'b1); drain();
    check_log("t4_order", 8'b0000_0000, 8);

    // B writes 0xC3 at the top address and reads it on the next grant.
    pb.push_back(wr(4'd15, 8'hC3));
    pb.push_back(rd(4'd15, 8'hC3));
    run_ops(1'b1); drain();
    check_log("t3_order", 8'b11, 2);

    // Continuous contention of reads: A,B,A,B,A,B.
    pa.push_back(rd(4'd0, 8'h10));
    pa.push_back(rd(4'd1, 8'h11));
    pa.push_back(rd(4'd2, 8'h12));
    pb.push_back(rd(4'd15, 8'hC3));
    pb.push_back(rd(4'd3, 8'h13));
    pb.push_back(rd(4'd0, 8'h10));
    run_ops(1'b1); drain();
    check_log("t2_alternate", 8'b0010_1010, 6);

    // Read granted, then reset pulsed the following cycle: read is dropped.
    pa.push_back(rd(4'd2, 8'h12));
    run_ops(1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_read_write", 32'(bus.mem_read_write), 32'd0);
    chk("midrst_mem_address",    32'(bus.mem_address),    32'd0);
    chk("midrst_rvalid_a",       32'(bus.rvalid_a),       32'd0);
    chk("midrst_rvalid_b",       32'(bus.rvalid_b),       32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_log("t5_pre", 8'b0, 1);
    drain();
    pa.push_back(rd(4'd3, 8'h13));
    pb.push_back(rd(4'd15, 8'hC3));
    run_ops(1'b1); drain();
    check_log("t5_post_reset_contention", 8'b10, 2);

    // Ten idle cycles, then read back to confirm nothing was disturbed.
    repeat (10) begin
      @(negedge clk);
      chk("idle_mem_read_write", 32'(bus.mem_read_write), 32'd0);
      chk("idle_gnt", 32'(bus.gnt_a | bus.gnt_b), 32'd0);
      chk("idle_rvalid", 32'(bus.rvalid_a | bus.rvalid_b), 32'd0);
    end
    pa.push_back(rd(4'd2, 8'h12));
    pa.push_back(rd(4'd0, 8'h10));
    pb.push_back(rd(4'd15, 8'hC3));
    run_ops(1'b1); drain();
    check_log("t6_order", 8'b010, 3);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory (write when read_write=1, else registered read; 1-cycle read latency) between two requesters, A and B.
- Round-robin arbitration and a valid/grant handshake per requester.
- Drives the memory's read_write/address/data_in from registers and returns read data with a per-requester valid strobe.
- Fully pipelined: one access per cycle.

Parameters:
- data_length, 8, width of memory data words
- addr_length, 4, width of memory address (depth 2**addr_length)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_a  in  1  requester A access request, held until gnt_a
- we_a  in  1  A access type: 1=write, 0=read
- addr_a  in  addr_length  A address
- wdata_a  in  data_length  A write data
- gnt_a  out  1  A request accepted this cycle (combinational)
- rvalid_a  out  1  rdata holds A's read result this cycle
- req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b  as above for B
- rdata  out  data_length  read data, shared, qualified by rvalid_a/rvalid_b
- mem_read_write  out  1  to memory read_write
- mem_address  out  addr_length  to memory address
- mem_data_in  out  data_length  to memory data_in
- mem_data_out  in  data_length  from memory data_out

Behaviour:
- Reset (async, rst_n=0): mem_read_write=0, mem_address=0, mem_data_in=0, rvalid_a=rvalid_b=0, pipeline valids=0, last_owner=B (so A wins first contention). gnt_a/gnt_b=0 while rst_n=0.
- Arbitration (cycle N, combinational):
  - Only A requests -> gnt_a=1. Only B requests -> gnt_b=1.
  - Both request -> grant the requester that is not last_owner.
  - At most one gnt per cycle. gnt is never asserted without the matching req.
  - last_owner updates on every grant.
- Issue stage (edge ending N): the winner's we/addr/wdata are registered into mem_read_write/mem_address/mem_data_in.
  - Stage-1 tag {valid, owner, is_read} is registered alongside.
  - No grant -> mem_read_write=0, address/data hold; this idle read is harmless and its tag valid=0.
- Memory stage (cycle N+1): memory samples the command at the edge ending N+1.
  - Writes complete there.
  - Stage-1 tag moves to stage-2.
- Return stage (cycle N+2): stage-2 valid & is_read asserts rvalid_<owner> for exactly one cycle.
  - rdata = mem_data_out, passed through combinationally.
  - Writes produce no rvalid.
- Latency: grant-to-rvalid = 2 cycles. Throughput: 1 access/cycle; back-to-back grants allowed.
- Ordering: accesses hit memory in grant order.
  - A read granted the cycle after a write to the same address returns the new data.
  - A read granted the same cycle cannot occur (single grant).
- Requester contract: req/we/addr/wdata stable from req rise until the cycle gnt=1 inclusive. req may be dropped the cycle after gnt, or held for another access.
- Address wrap: none internally; addr passed through unmodified, full range 0..2**addr_length-1.
- Reset mid-operation: in-flight reads are discarded, no rvalid is emitted after rst_n rises, and memory contents are not cleared. First grant after reset follows the reset last_owner.
- rdata value is unspecified when both rvalids are 0. rvalid_a and rvalid_b are never both 1.

Decomposition:
- Shared package mem_arb_pkg: DATA_LENGTH/ADDR_LENGTH defaults, owner encoding constants OWNER_A=0 and OWNER_B=1, pipeline tag struct {valid, owner, is_read}.
- Sub-module rr_arb2: 2-way round-robin picker holding last_owner; inputs req_a, req_b; outputs gnt_a, gnt_b.
- Top holds the issue registers and the 2-stage tag pipeline.

Test Plan:
- After reset: A writes 0x5A at addr 3 (gnt_a same cycle), then A reads addr 3 -> rvalid_a exactly 2 cycles after read grant, rdata=0x5A, rvalid_b stays 0.
- A and B request continuously, both reads -> grants alternate A,B,A,B starting with A; rvalid pattern alternates, each 2 cycles after its grant.
- B writes 0xC3 at addr 15 then immediately reads addr 15 on the next grant -> rdata=0xC3, proving write-then-read ordering at the top address.
- A issues 4 back-to-back reads of addrs 0..3, preloaded with 0x10..0x13 -> rvalid_a high 4 consecutive cycles, rdata 0x10,0x11,0x12,0x13.
- A read is granted, then rst_n is pulsed low one cycle later -> mem_read_write=0 and rvalids=0 immediately; no rvalid after release; next contention is granted to A.
- No requests for 10 cycles -> mem_read_write=0 throughout, no gnt, no rvalid, memory contents unchanged (verified by later reads).
